// File: rtl/fetch_ifid_ctrl.sv
// Fetch control and IF/ID pipeline register.
// Owns the PC, honours stall/flush, and drains HLT into a sticky halt.
module fetch_ifid_ctrl #(
   parameter int unsigned PC_W      = 16,
   parameter int unsigned INSTR_W   = 16,
   parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
   parameter logic [3:0]         HALT_OP   = 4'hF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    branch_target,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc_plus2,
   output logic               ifid_valid,
   output logic [3:0]         ifid_rs,
   output logic [3:0]         ifid_rt,
   output logic               halted
);

   typedef enum logic [1:0] {
      RUN,
      HALT_PEND,
      HALTED
   } state_t;

   state_t state;

   logic [PC_W-1:0] pc_next;
   logic            is_hlt;

   assign pc_next = pc_out + PC_W'(2);
   assign is_hlt  = (imem_instr[15:12] == HALT_OP);

   assign ifid_rs = ifid_instr[7:4];
   assign ifid_rt = ifid_instr[3:0];

   // ifid_pc_plus2 is left untouched on bubbles; it is only meaningful when valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= RUN;
         pc_out        <= RESET_PC;
         ifid_instr    <= NOP_INSTR;
         ifid_pc_plus2 <= '0;
         ifid_valid    <= 1'b0;
         halted        <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (flush) begin
                  pc_out     <= branch_target;
                  ifid_instr <= NOP_INSTR;
                  ifid_valid <= 1'b0;
               end else if (!stall) begin
                  ifid_instr    <= imem_instr;
                  ifid_pc_plus2 <= pc_next;
                  ifid_valid    <= 1'b1;
                  if (is_hlt) begin
                     state <= HALT_PEND;
                  end else begin
                     pc_out <= pc_next;
                  end
               end
            end
            HALT_PEND: begin
               if (flush) begin
                  pc_out     <= branch_target;
                  ifid_instr <= NOP_INSTR;
                  ifid_valid <= 1'b0;
                  state      <= RUN;
               end else if (!stall) begin
                  ifid_instr <= NOP_INSTR;
                  ifid_valid <= 1'b0;
                  state      <= HALTED;
                  halted     <= 1'b1;
               end
            end
            HALTED: begin
               halted <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ifid_ctrl.sv
// Bench for fetch_ifid_ctrl: behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_ifid_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [15:0] branch_target;
   logic [15:0] imem_instr;
   logic [15:0] pc_out;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus2;
   logic        ifid_valid;
   logic [3:0]  ifid_rs;
   logic [3:0]  ifid_rt;
   logic        halted;

   logic [15:0] hlt_pc;
   int          total = 0;
   int          passed = 0;
   logic        chk_en = 1'b0;

   fetch_ifid_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .branch_target (branch_target),
      .imem_instr    (imem_instr),
      .pc_out        (pc_out),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus2 (ifid_pc_plus2),
      .ifid_valid    (ifid_valid),
      .ifid_rs       (ifid_rs),
      .ifid_rt       (ifid_rt),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] imem_of(
      input logic [15:0] a, input logic [15:0] h);
      if (a == h) return 16'hF000;
      if (a == 16'h0008) return 16'h8123;
      return {4'h2, a[11:0]};
   endfunction

   assign imem_instr = imem_of(pc_out, hlt_pc);

   // Model: a valid HLT sitting in IF/ID means the halt is pending.
   logic [15:0] m_pc, m_instr, m_pp2;
   logic        m_valid, m_halted;
   logic [15:0] m_f;

   always @(posedge clk) begin
      m_f = imem_of(m_pc, hlt_pc);
      if (!rst_n) begin
         m_pc     <= 16'h0000;
         m_instr  <= 16'h0000;
         m_valid  <= 1'b0;
         m_halted <= 1'b0;
      end else if (m_halted) begin
         m_pc <= m_pc;
      end else if (flush) begin
         m_pc    <= branch_target;
         m_instr <= 16'h0000;
         m_valid <= 1'b0;
      end else if (stall) begin
         m_pc <= m_pc;
      end else if (m_valid && m_instr[15:12] == 4'hF) begin
         m_instr  <= 16'h0000;
         m_valid  <= 1'b0;
         m_halted <= 1'b1;
      end else begin
         m_instr <= m_f;
         m_valid <= 1'b1;
         m_pp2   <= m_pc + 16'd2;
         if (m_f[15:12] != 4'hF) m_pc <= m_pc + 16'd2;
      end
   end

   task automatic chk(input string name,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t",
                    name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_pc", pc_out, m_pc);
         chk("cyc_instr", ifid_instr, m_instr);
         chk("cyc_valid", 16'(ifid_valid), 16'(m_valid));
         chk("cyc_rs", 16'(ifid_rs), 16'(m_instr[7:4]));
         chk("cyc_rt", 16'(ifid_rt), 16'(m_instr[3:0]));
         chk("cyc_halted", 16'(halted), 16'(m_halted));
         if (m_valid) chk("cyc_pp2", ifid_pc_plus2, m_pp2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      stall         = 1'b0;
      flush         = 1'b0;
      branch_target = 16'h0000;
      hlt_pc        = 16'hFFFF;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_valid", 16'(ifid_valid), 16'h0);
      chk("rst_instr", ifid_instr, 16'h0000);
      chk("rst_halted", 16'(halted), 16'h0);

      // 1: straight-line fetch
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("seq_pc", pc_out, 16'(2 * i));
         chk("seq_pp2", ifid_pc_plus2, 16'(2 * i));
      end
      chk("seq_instr", ifid_instr, 16'h2006);
      tick();
      chk("ld_8123", ifid_instr, 16'h8123);

      // 2: stall holds everything
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stl_pc", pc_out, 16'h000A);
         chk("stl_instr", ifid_instr, 16'h8123);
         chk("stl_rs", 16'(ifid_rs), 16'h2);
         chk("stl_rt", 16'(ifid_rt), 16'h3);
      end
      stall = 1'b0;

      // 4: HLT at 000A drains into halted
      hlt_pc = 16'h000A;
      tick();
      chk("hlt_ifid", ifid_instr, 16'hF000);
      chk("hlt_pc", pc_out, 16'h000A);
      chk("hlt_valid", 16'(ifid_valid), 16'h1);
      chk("hlt_pp2", ifid_pc_plus2, 16'h000C);
      tick();
      chk("hlt_bub", 16'(ifid_valid), 16'h0);
      chk("hlt_halted", 16'(halted), 16'h1);
      flush = 1'b1;
      branch_target = 16'h0040;
      tick();
      flush = 1'b0;
      stall = 1'b1;
      tick();
      stall = 1'b0;
      tick();
      chk("frz_pc", pc_out, 16'h000A);
      chk("frz_halted", 16'(halted), 16'h1);

      // 5: wrong-path HLT squashed by flush
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      hlt_pc = 16'h0004;
      tick();
      tick();
      tick();
      chk("hp_ifid", ifid_instr, 16'hF000);
      flush = 1'b1;
      branch_target = 16'h0020;
      tick();
      flush = 1'b0;
      hlt_pc = 16'hFFFF;
      chk("hp_pc", pc_out, 16'h0020);
      chk("hp_valid", 16'(ifid_valid), 16'h0);
      tick();
      chk("hp_halted", 16'(halted), 16'h0);
      chk("hp_adv", pc_out, 16'h0022);

      // 3: flush wins over stall
      flush = 1'b1;
      stall = 1'b1;
      branch_target = 16'h0040;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      chk("fs_pc", pc_out, 16'h0040);
      chk("fs_model_pc", m_pc, 16'h0040);
      chk("fs_valid", 16'(ifid_valid), 16'h0);
      chk("fs_instr", ifid_instr, 16'h0000);

      // 6: wrap at FFFE, then reset out of HALTED
      flush = 1'b1;
      branch_target = 16'hFFFE;
      tick();
      flush = 1'b0;
      chk("wr_pc0", pc_out, 16'hFFFE);
      tick();
      chk("wr_pc", pc_out, 16'h0000);
      chk("wr_pp2", ifid_pc_plus2, 16'h0000);
      chk("wr_instr", ifid_instr, 16'h2FFE);
      hlt_pc = 16'h0002;
      tick();
      tick();
      tick();
      chk("wr_halted", 16'(halted), 16'h1);
      chk("wr_model_h", 16'(m_halted), 16'h1);
      rst_n = 1'b0;
      stall = 1'b1;
      tick();
      chk("rh_pc", pc_out, 16'h0000);
      chk("rh_halted", 16'(halted), 16'h0);
      chk("rh_valid", 16'(ifid_valid), 16'h0);
      stall = 1'b0;
      tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
